// File: rtl/gfx_addr_sched.sv
// Round-robin scheduler sharing one gfx address calculator among NREQ requesters.
// Shadows bitmap config, waits for the calculator's width register to settle, returns tagged results.
module gfx_addr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int BN   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          cfg_base_i,
    input  logic [1:0]           cfg_depth_i,
    input  logic [15:0]          cfg_width_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*16-1:0]   req_x_i,
    input  logic [NREQ*16-1:0]   req_y_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [31:0]          calc_base_o,
    output logic [1:0]           calc_depth_o,
    output logic [15:0]          calc_width_o,
    output logic [15:0]          calc_x_o,
    output logic [15:0]          calc_y_o,
    input  logic [31:0]          calc_addr_i,
    input  logic [BN:0]          calc_mb_i,
    input  logic [BN:0]          calc_me_i,
    input  logic [BN:0]          calc_ce_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IDW-1:0]       out_id_o,
    output logic [31:0]          out_addr_o,
    output logic [BN:0]          out_mb_o,
    output logic [BN:0]          out_me_o,
    output logic [BN:0]          out_ce_o
);
    // Output handshake: a result transfers on a clock edge where out_valid_o && out_ready_i;
    // until then every out_* signal holds its value.
    typedef enum logic [1:0] {IDLE, SETTLE, CALC, OUT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [1:0]      depth_q, depth_d;
    logic [15:0]     width_q, width_d;
    logic [1:0]      settle_q, settle_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [15:0]     x_q, x_d;
    logic [15:0]     y_q, y_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            valid_q, valid_d;
    logic [IDW-1:0]  oid_q, oid_d;
    logic [31:0]     oaddr_q, oaddr_d;
    logic [BN:0]     omb_q, omb_d;
    logic [BN:0]     ome_q, ome_d;
    logic [BN:0]     oce_q, oce_d;

    logic [15:0]     x_arr [NREQ];
    logic [15:0]     y_arr [NREQ];
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [IDW:0]    cand;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign x_arr[k] = req_x_i[16*k +: 16];
        assign y_arr[k] = req_y_i[16*k +: 16];
    end

    // Search starts just after the last winner, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (!grant_found && req_i[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        depth_d  = depth_q;
        width_d  = width_q;
        settle_d = settle_q;
        rr_d     = rr_q;
        id_d     = id_q;
        x_d      = x_q;
        y_d      = y_q;
        ack_d    = '0;
        valid_d  = valid_q;
        oid_d    = oid_q;
        oaddr_d  = oaddr_q;
        omb_d    = omb_q;
        ome_d    = ome_q;
        oce_d    = oce_q;
        case (state_q)
            IDLE: begin
                if (cfg_depth_i != depth_q || cfg_width_i != width_q) begin
                    base_d   = cfg_base_i;
                    depth_d  = cfg_depth_i;
                    width_d  = cfg_width_i;
                    settle_d = 2'd2;
                    state_d  = SETTLE;
                end else if (cfg_base_i != base_q) begin
                    base_d = cfg_base_i;
                end else if (grant_found) begin
                    x_d             = x_arr[grant_id];
                    y_d             = y_arr[grant_id];
                    id_d            = grant_id;
                    ack_d[grant_id] = 1'b1;
                    rr_d            = grant_id;
                    state_d         = CALC;
                end
            end
            // Two edges: calculator input update, then its strips-per-line register.
            SETTLE: begin
                if (settle_q <= 2'd1) begin
                    settle_d = '0;
                    state_d  = IDLE;
                end else begin
                    settle_d = settle_q - 2'd1;
                end
            end
            CALC: begin
                oid_d   = id_q;
                oaddr_d = calc_addr_i;
                omb_d   = calc_mb_i;
                ome_d   = calc_me_i;
                oce_d   = calc_ce_i;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (valid_q && out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            depth_q  <= '0;
            width_q  <= '0;
            settle_q <= '0;
            rr_q     <= IDW'(NREQ-1);
            id_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ack_q    <= '0;
            valid_q  <= 1'b0;
            oid_q    <= '0;
            oaddr_q  <= '0;
            omb_q    <= '0;
            ome_q    <= '0;
            oce_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            depth_q  <= depth_d;
            width_q  <= width_d;
            settle_q <= settle_d;
            rr_q     <= rr_d;
            id_q     <= id_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ack_q    <= ack_d;
            valid_q  <= valid_d;
            oid_q    <= oid_d;
            oaddr_q  <= oaddr_d;
            omb_q    <= omb_d;
            ome_q    <= ome_d;
            oce_q    <= oce_d;
        end
    end

    assign ack_o        = ack_q;
    assign calc_base_o  = base_q;
    assign calc_depth_o = depth_q;
    assign calc_width_o = width_q;
    assign calc_x_o     = x_q;
    assign calc_y_o     = y_q;
    assign out_valid_o  = valid_q;
    assign out_id_o     = oid_q;
    assign out_addr_o   = oaddr_q;
    assign out_mb_o     = omb_q;
    assign out_me_o     = ome_q;
    assign out_ce_o     = oce_q;

endmodule

// File: tb/tb_gfx_addr_sched.sv
// Bench for gfx_addr_sched: behavioural address calculator, directed requests,
// scoreboard queues for grants and results checked by independent monitors.
`timescale 1ns/1ps
module tb_gfx_addr_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int BN   = 6;
    localparam int W    = IDW + 32 + 3*(BN+1);
    localparam logic [1:0] BPP16 = 2'd1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [31:0]         cfg_base;
    logic [1:0]          cfg_depth;
    logic [15:0]         cfg_width;
    logic [NREQ-1:0]     req;
    logic [NREQ*16-1:0]  req_x, req_y;
    logic [NREQ-1:0]     ack;
    logic [31:0]         calc_base;
    logic [1:0]          calc_depth;
    logic [15:0]         calc_width, calc_x, calc_y;
    logic [31:0]         calc_addr;
    logic [BN:0]         calc_mb, calc_me, calc_ce;
    logic                out_valid, out_ready;
    logic [IDW-1:0]      out_id;
    logic [31:0]         out_addr;
    logic [BN:0]         out_mb, out_me, out_ce;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0]   exp_q[$];
    logic [IDW-1:0] exp_ack_q[$];

    always #5 clk = ~clk;

    gfx_addr_sched #(.NREQ(NREQ), .IDW(IDW), .BN(BN)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_base_i(cfg_base), .cfg_depth_i(cfg_depth), .cfg_width_i(cfg_width),
        .req_i(req), .req_x_i(req_x), .req_y_i(req_y), .ack_o(ack),
        .calc_base_o(calc_base), .calc_depth_o(calc_depth), .calc_width_o(calc_width),
        .calc_x_o(calc_x), .calc_y_o(calc_y),
        .calc_addr_i(calc_addr), .calc_mb_i(calc_mb), .calc_me_i(calc_me), .calc_ce_i(calc_ce),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
        .out_addr_o(out_addr), .out_mb_o(out_mb), .out_me_o(out_me), .out_ce_o(out_ce)
    );

    // Calculator model: 128-bit strips, combinational x/y, registered strips-per-line.
    function automatic int bpp_of(input logic [1:0] d);
        case (d)
            2'd0: return 8;
            2'd1: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int cbits_of(input logic [1:0] d);
        case (d)
            2'd0: return 8;
            2'd1: return 12;
            2'd2: return 24;
            default: return 32;
        endcase
    endfunction

    logic [15:0] spl_q;
    int          m_bits, m_cbits;
    longint      m_off, m_addr;

    always @(posedge clk)
        spl_q <= 16'((longint'(calc_width) * bpp_of(calc_depth) + 127) / 128);

    always_comb begin
        m_bits    = bpp_of(calc_depth);
        m_cbits   = cbits_of(calc_depth);
        m_off     = longint'(calc_x) * m_bits;
        m_addr    = longint'(calc_base) + (longint'(calc_y) * longint'(spl_q) + m_off / 128) * 16;
        calc_addr = m_addr[31:0];
        calc_mb   = (BN+1)'(m_off % 128);
        calc_me   = (BN+1)'(m_off % 128 + m_bits - 1);
        calc_ce   = (BN+1)'(m_off % 128 + m_cbits - 1);
    end

    function automatic logic [W-1:0] pk(input logic [IDW-1:0] id, input logic [31:0] a,
                                        input logic [BN:0] mb, input logic [BN:0] me,
                                        input logic [BN:0] ce);
        return {id, a, mb, me, ce};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [15:0] x, input logic [15:0] y);
        req_x[16*k +: 16] = x;
        req_y[16*k +: 16] = y;
        req[k] = 1'b1;
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [31:0] a,
                        input logic [BN:0] mb, input logic [BN:0] me, input logic [BN:0] ce);
        exp_ack_q.push_back(id);
        exp_q.push_back(pk(id, a, mb, me, ce));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_ack_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < budget), 64'd1);
        repeat (3) tick();
    endtask

    // Result monitor: compares on every accepted output.
    logic [W-1:0] om_exp;
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 64'(out_id), 64'hFFFF);
            end else begin
                om_exp = exp_q.pop_front();
                chk("out_pkt", 64'(pk(out_id, out_addr, out_mb, out_me, out_ce)), 64'(om_exp));
            end
        end
    end

    // Grant monitor: each ack pulse must be the next expected one-hot grant.
    logic [NREQ-1:0] am_exp;
    always @(negedge clk) begin
        if (ack != '0) begin
            if (exp_ack_q.size() == 0) begin
                chk("ack_unexpected", 64'(ack), 64'd0);
            end else begin
                am_exp = '0;
                am_exp[exp_ack_q.pop_front()] = 1'b1;
                chk("ack_order", 64'(ack), 64'(am_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; cfg_base = '0; cfg_depth = '0; cfg_width = '0;
        req = '0; req_x = '0; req_y = '0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_calc_x", 64'(calc_x), 64'd0);
        chk("rst_calc_y", 64'(calc_y), 64'd0);
        chk("rst_calc_base", 64'(calc_base), 64'd0);
        chk("rst_calc_width", 64'(calc_width), 64'd0);

        rst_n = 1'b1;
        cfg_base = 32'h1000_0000; cfg_depth = BPP16; cfg_width = 16'd640;
        repeat (4) tick();
        chk("cfg_width", 64'(calc_width), 64'd640);
        chk("cfg_depth", 64'(calc_depth), 64'(BPP16));
        chk("cfg_base", 64'(calc_base), 64'h1000_0000);

        // Round robin from reset pointer: 0,1,2,3,0.
        push(0, 32'h1000_0A10, 7'd16, 7'd31, 7'd27);
        push(1, 32'h1000_0000, 7'd0, 7'd15, 7'd11);
        push(2, 32'h1000_05C0, 7'd64, 7'd79, 7'd75);
        push(3, 32'h1009_5FF0, 7'd112, 7'd127, 7'd123);
        push(0, 32'h1000_0A10, 7'd16, 7'd31, 7'd27);
        set_req(0, 16'd9, 16'd2);
        set_req(1, 16'd0, 16'd0);
        set_req(2, 16'd100, 16'd1);
        set_req(3, 16'd639, 16'd479);
        cnt = 0;
        for (int i = 0; i < 40 && cnt < 5; i++) begin
            tick();
            if (ack != '0) cnt++;
            if (cnt == 5) req = '0;
        end
        req = '0;
        chk("rr_grant_count", 64'(cnt), 64'd5);
        drain(30);

        // Basic latency.
        push(0, 32'h1000_0A10, 7'd16, 7'd31, 7'd27);
        set_req(0, 16'd9, 16'd2);
        tick();
        chk("basic_ack", 64'(ack), 64'h1);
        chk("basic_valid_early", 64'(out_valid), 64'd0);
        req[0] = 1'b0;
        tick();
        chk("basic_ack_pulse", 64'(ack), 64'd0);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_addr", 64'(out_addr), 64'h1000_0A10);
        drain(20);

        // Backpressure with req1 waiting behind a held result.
        out_ready = 1'b0;
        push(0, 32'h1000_0500, 7'd16, 7'd31, 7'd27);
        set_req(0, 16'd1, 16'd1);
        tick();
        chk("bp_ack0", 64'(ack), 64'h1);
        req[0] = 1'b0;
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        push(1, 32'h1000_0F20, 7'd0, 7'd15, 7'd11);
        set_req(1, 16'd16, 16'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_no_ack", 64'(ack), 64'd0);
            chk("bp_hold_addr", 64'(out_addr), 64'h1000_0500);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_mb", 64'(out_mb), 64'd16);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 64'(out_valid), 64'd0);
        chk("bp_accept_ack", 64'(ack), 64'd0);
        tick();
        chk("bp_ack1", 64'(ack), 64'h2);
        req[1] = 1'b0;
        drain(20);

        // Width change in the same cycle as req2: two settle cycles, then grant.
        push(2, 32'h1000_0510, 7'd16, 7'd31, 7'd27);
        cfg_width = 16'd320;
        set_req(2, 16'd9, 16'd2);
        tick();
        chk("settle_no_ack0", 64'(ack), 64'd0);
        chk("settle_width", 64'(calc_width), 64'd320);
        tick();
        chk("settle_no_ack1", 64'(ack), 64'd0);
        tick();
        chk("settle_no_ack2", 64'(ack), 64'd0);
        tick();
        chk("settle_ack2", 64'(ack), 64'h4);
        req[2] = 1'b0;
        drain(20);

        // Config change while a result is held in OUT.
        out_ready = 1'b0;
        push(3, 32'h1000_0510, 7'd16, 7'd31, 7'd27);
        set_req(3, 16'd9, 16'd2);
        tick();
        chk("out_cfg_ack3", 64'(ack), 64'h8);
        req[3] = 1'b0;
        tick();
        chk("out_cfg_valid", 64'(out_valid), 64'd1);
        cfg_width = 16'd640;
        cfg_base  = 32'h2000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("out_cfg_shadow_width", 64'(calc_width), 64'd320);
            chk("out_cfg_shadow_base", 64'(calc_base), 64'h1000_0000);
            chk("out_cfg_hold_addr", 64'(out_addr), 64'h1000_0510);
        end
        out_ready = 1'b1;
        tick();
        chk("out_cfg_accept", 64'(out_valid), 64'd0);
        tick();
        chk("out_cfg_new_width", 64'(calc_width), 64'd640);
        chk("out_cfg_new_base", 64'(calc_base), 64'h2000_0000);
        drain(20);

        // Reset while in CALC; first grant afterwards goes to requester 0.
        exp_ack_q.push_back(1);
        set_req(1, 16'd5, 16'd5);
        tick();
        chk("rst_mid_ack1", 64'(ack), 64'h2);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_ack", 64'(ack), 64'd0);
        req = '1;
        set_req(0, 16'd9, 16'd2);
        tick();
        chk("rst_hold_ack", 64'(ack), 64'd0);
        push(0, 32'h2000_0A10, 7'd16, 7'd31, 7'd27);
        rst_n = 1'b1;
        tick();
        chk("rst_exit_ack0", 64'(ack), 64'd0);
        tick();
        chk("rst_exit_ack1", 64'(ack), 64'd0);
        tick();
        chk("rst_exit_ack2", 64'(ack), 64'd0);
        tick();
        chk("rst_first_grant", 64'(ack), 64'h1);
        req = '0;
        drain(20);

        chk("final_out_queue", 64'(exp_q.size()), 64'd0);
        chk("final_ack_queue", 64'(exp_ack_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
